// File: rtl/wheel_kinematics_engine.sv
// Mecanum wheel inverse kinematics in sign-magnitude fixed point.
// One shared saturating multiplier is sequenced over eight FSM states per request.
module wheel_kinematics_engine #(
    parameter int                 N_WIDTH    = 17,
    parameter int                 Q_WIDTH    = 8,
    parameter logic [N_WIDTH-1:0] K1_COEF    = 17'h0002A,
    parameter logic [N_WIDTH-1:0] INV_R_COEF = 17'h01B96
) (
    input  logic               WHEEL_KINEMATICS_ENGINE_CLOCK_50,
    input  logic               WHEEL_KINEMATICS_ENGINE_RESET_InLow,
    input  logic [N_WIDTH-1:0] WHEEL_KINEMATICS_ENGINE_TARGETVX_InBus,
    input  logic [N_WIDTH-1:0] WHEEL_KINEMATICS_ENGINE_TARGETVY_InBus,
    input  logic [N_WIDTH-1:0] WHEEL_KINEMATICS_ENGINE_TARGETWZ_InBus,
    input  logic               WHEEL_KINEMATICS_ENGINE_valid_InHigh,
    output logic               WHEEL_KINEMATICS_ENGINE_ready_OutHigh,
    output logic [N_WIDTH-1:0] WHEEL_KINEMATICS_ENGINE_W1_OutBus,
    output logic [N_WIDTH-1:0] WHEEL_KINEMATICS_ENGINE_W2_OutBus,
    output logic [N_WIDTH-1:0] WHEEL_KINEMATICS_ENGINE_W3_OutBus,
    output logic [N_WIDTH-1:0] WHEEL_KINEMATICS_ENGINE_W4_OutBus,
    output logic               WHEEL_KINEMATICS_ENGINE_done_OutHigh,
    output logic               WHEEL_KINEMATICS_ENGINE_overflow_OutHigh
);
    localparam int M_WIDTH = N_WIDTH - 1;
    localparam int S_WIDTH = N_WIDTH + 2;
    localparam int P_WIDTH = 2 * M_WIDTH;
    localparam logic [M_WIDTH-1:0] MAG_MAX  = {M_WIDTH{1'b1}};
    localparam logic [M_WIDTH-1:0] MAG_ZERO = {M_WIDTH{1'b0}};
    localparam logic [N_WIDTH-1:0] WORD_ZERO = {N_WIDTH{1'b0}};

    typedef enum logic [2:0] {
        IDLE = 3'd0, MULK = 3'd1, SUM = 3'd2, SC1 = 3'd3,
        SC2  = 3'd4, SC3  = 3'd5, SC4 = 3'd6, DONE = 3'd7
    } state_t;

    // Sign-magnitude to two's complement; -0 collapses to 0 naturally.
    function automatic logic signed [S_WIDTH-1:0] sm_to_int(input logic [N_WIDTH-1:0] v);
        logic signed [S_WIDTH-1:0] mag_v;
        mag_v = $signed({3'b000, v[M_WIDTH-1:0]});
        if (v[N_WIDTH-1]) begin
            return -mag_v;
        end else begin
            return mag_v;
        end
    endfunction

    // Returns {overflow, sign-magnitude word}, saturated, zero always positive.
    function automatic logic [N_WIDTH:0] int_to_sm(input logic signed [S_WIDTH-1:0] v);
        logic [S_WIDTH-1:0] abs_v;
        logic [M_WIDTH-1:0] mag_v;
        logic               ovf_v;
        abs_v = v[S_WIDTH-1] ? $unsigned(-v) : $unsigned(v);
        if (abs_v > {3'b000, MAG_MAX}) begin
            ovf_v = 1'b1;
            mag_v = MAG_MAX;
        end else begin
            ovf_v = 1'b0;
            mag_v = abs_v[M_WIDTH-1:0];
        end
        return {ovf_v, v[S_WIDTH-1] && (mag_v != MAG_ZERO), mag_v};
    endfunction

    // Truncating Q-format rescale of a raw magnitude product, with saturation.
    function automatic logic [N_WIDTH:0] prod_to_sm(input logic sign_v, input logic [P_WIDTH-1:0] prod_v);
        logic [P_WIDTH-1:0] shr_v;
        logic [M_WIDTH-1:0] mag_v;
        logic               ovf_v;
        shr_v = prod_v >> Q_WIDTH;
        if (shr_v > {{(P_WIDTH-M_WIDTH){1'b0}}, MAG_MAX}) begin
            ovf_v = 1'b1;
            mag_v = MAG_MAX;
        end else begin
            ovf_v = 1'b0;
            mag_v = shr_v[M_WIDTH-1:0];
        end
        return {ovf_v, sign_v && (mag_v != MAG_ZERO), mag_v};
    endfunction

    state_t             state_r, state_nxt_s;
    logic [N_WIDTH-1:0] vx_r, vy_r, wz_r, t_r;
    logic [N_WIDTH-1:0] s1_r, s2_r, s3_r, s4_r;
    logic [N_WIDTH-1:0] r1_r, r2_r, r3_r;
    logic [N_WIDTH-1:0] w1_r, w2_r, w3_r, w4_r;
    logic               ovf_acc_r, ovf_r, done_r, ready_r;
    logic [N_WIDTH-1:0] mul_a_s, mul_b_s;
    logic [P_WIDTH-1:0] mul_prod_s;
    logic [N_WIDTH:0]   mul_res_s;
    logic signed [S_WIDTH-1:0] vx_i_s, vy_i_s, t_i_s;
    logic [N_WIDTH:0]   sum1_s, sum2_s, sum3_s, sum4_s;

    assign vx_i_s = sm_to_int(vx_r);
    assign vy_i_s = sm_to_int(vy_r);
    assign t_i_s  = sm_to_int(t_r);
    assign sum1_s = int_to_sm(vx_i_s - vy_i_s - t_i_s);
    assign sum2_s = int_to_sm(vx_i_s + vy_i_s + t_i_s);
    assign sum3_s = int_to_sm(vx_i_s + vy_i_s - t_i_s);
    assign sum4_s = int_to_sm(vx_i_s - vy_i_s + t_i_s);

    assign mul_prod_s = {{M_WIDTH{1'b0}}, mul_a_s[M_WIDTH-1:0]} * {{M_WIDTH{1'b0}}, mul_b_s[M_WIDTH-1:0]};
    assign mul_res_s  = prod_to_sm(mul_a_s[N_WIDTH-1] ^ mul_b_s[N_WIDTH-1], mul_prod_s);

    // Operand select for the single shared multiplier.
    always_comb begin
        mul_a_s = INV_R_COEF;
        mul_b_s = s1_r;
        case (state_r)
            MULK: begin
                mul_a_s = K1_COEF;
                mul_b_s = wz_r;
            end
            SC1:     mul_b_s = s1_r;
            SC2:     mul_b_s = s2_r;
            SC3:     mul_b_s = s3_r;
            SC4:     mul_b_s = s4_r;
            default: mul_b_s = s1_r;
        endcase
    end

    // Next-state sequencing: fixed eight-cycle walk once a request is taken.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (WHEEL_KINEMATICS_ENGINE_valid_InHigh) begin
                    state_nxt_s = MULK;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MULK:    state_nxt_s = SUM;
            SUM:     state_nxt_s = SC1;
            SC1:     state_nxt_s = SC2;
            SC2:     state_nxt_s = SC3;
            SC3:     state_nxt_s = SC4;
            SC4:     state_nxt_s = DONE;
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register with registered handshake flags.
    always_ff @(posedge WHEEL_KINEMATICS_ENGINE_CLOCK_50) begin
        if (!WHEEL_KINEMATICS_ENGINE_RESET_InLow) begin
            state_r <= IDLE;
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= (state_nxt_s == DONE);
            ready_r <= (state_nxt_s == IDLE);
        end
    end

    // Datapath: operand capture, intermediate terms, and result publication.
    always_ff @(posedge WHEEL_KINEMATICS_ENGINE_CLOCK_50) begin
        if (!WHEEL_KINEMATICS_ENGINE_RESET_InLow) begin
            vx_r <= WORD_ZERO; vy_r <= WORD_ZERO; wz_r <= WORD_ZERO; t_r <= WORD_ZERO;
            s1_r <= WORD_ZERO; s2_r <= WORD_ZERO; s3_r <= WORD_ZERO; s4_r <= WORD_ZERO;
            r1_r <= WORD_ZERO; r2_r <= WORD_ZERO; r3_r <= WORD_ZERO;
            w1_r <= WORD_ZERO; w2_r <= WORD_ZERO; w3_r <= WORD_ZERO; w4_r <= WORD_ZERO;
            ovf_acc_r <= 1'b0;
            ovf_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (WHEEL_KINEMATICS_ENGINE_valid_InHigh) begin
                        vx_r      <= WHEEL_KINEMATICS_ENGINE_TARGETVX_InBus;
                        vy_r      <= WHEEL_KINEMATICS_ENGINE_TARGETVY_InBus;
                        wz_r      <= WHEEL_KINEMATICS_ENGINE_TARGETWZ_InBus;
                        ovf_acc_r <= 1'b0;
                    end
                end
                MULK: begin
                    t_r       <= mul_res_s[N_WIDTH-1:0];
                    ovf_acc_r <= ovf_acc_r | mul_res_s[N_WIDTH];
                end
                SUM: begin
                    s1_r      <= sum1_s[N_WIDTH-1:0];
                    s2_r      <= sum2_s[N_WIDTH-1:0];
                    s3_r      <= sum3_s[N_WIDTH-1:0];
                    s4_r      <= sum4_s[N_WIDTH-1:0];
                    ovf_acc_r <= ovf_acc_r | sum1_s[N_WIDTH] | sum2_s[N_WIDTH]
                                           | sum3_s[N_WIDTH] | sum4_s[N_WIDTH];
                end
                SC1: begin
                    r1_r      <= mul_res_s[N_WIDTH-1:0];
                    ovf_acc_r <= ovf_acc_r | mul_res_s[N_WIDTH];
                end
                SC2: begin
                    r2_r      <= mul_res_s[N_WIDTH-1:0];
                    ovf_acc_r <= ovf_acc_r | mul_res_s[N_WIDTH];
                end
                SC3: begin
                    r3_r      <= mul_res_s[N_WIDTH-1:0];
                    ovf_acc_r <= ovf_acc_r | mul_res_s[N_WIDTH];
                end
                SC4: begin
                    // Last product goes straight out so all four wheels land together on DONE entry.
                    w1_r      <= r1_r;
                    w2_r      <= r2_r;
                    w3_r      <= r3_r;
                    w4_r      <= mul_res_s[N_WIDTH-1:0];
                    ovf_r     <= ovf_acc_r | mul_res_s[N_WIDTH];
                    ovf_acc_r <= ovf_acc_r | mul_res_s[N_WIDTH];
                end
                default: begin
                    ovf_acc_r <= ovf_acc_r;
                end
            endcase
        end
    end

    assign WHEEL_KINEMATICS_ENGINE_ready_OutHigh    = ready_r;
    assign WHEEL_KINEMATICS_ENGINE_done_OutHigh     = done_r;
    assign WHEEL_KINEMATICS_ENGINE_overflow_OutHigh = ovf_r;
    assign WHEEL_KINEMATICS_ENGINE_W1_OutBus        = w1_r;
    assign WHEEL_KINEMATICS_ENGINE_W2_OutBus        = w2_r;
    assign WHEEL_KINEMATICS_ENGINE_W3_OutBus        = w3_r;
    assign WHEEL_KINEMATICS_ENGINE_W4_OutBus        = w4_r;
endmodule
